// File: rtl/max7219_ctrl.sv
// Serial frame controller for a MAX7219 LED driver: accepts a 16-bit frame on a
// valid/ready handshake, shifts it out MSB first and strobes LOAD when done.
module max7219_ctrl #(
   parameter int G_CLK_DIV     = 4,
   parameter int G_LOAD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [15:0] i_data,
   output logic        o_ready,
   output logic        o_done,
   output logic        o_max7219_clk,
   output logic        o_max7219_din,
   output logic        o_max7219_load
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_LOAD
   } state_t;

   localparam logic [7:0] DIV_LAST  = 8'(G_CLK_DIV - 1);
   localparam logic [7:0] LOAD_LAST = 8'(G_LOAD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  phase_q, phase_d;
   logic [3:0]  bit_q, bit_d;
   logic [15:0] shreg_q, shreg_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        sclk_q, sclk_d;
   logic        din_q, din_d;
   logic        load_q, load_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         din_q   <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         din_q   <= din_d;
         load_q  <= load_d;
      end
   end

   // Output registers are loaded with the values belonging to the next state,
   // so every pin changes on the same edge as the state it reflects.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q + 8'd1;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      ready_d = 1'b0;
      done_d  = 1'b0;
      sclk_d  = sclk_q;
      din_d   = din_q;
      load_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            phase_d = '0;
            sclk_d  = 1'b0;
            din_d   = 1'b0;
            if (i_valid && ready_q) begin
               state_d = S_SHIFT_LO;
               shreg_d = i_data;
               din_d   = i_data[15];
               bit_d   = '0;
               ready_d = 1'b0;
            end
         end

         S_SHIFT_LO: begin
            sclk_d = 1'b0;
            if (phase_q == DIV_LAST) begin
               state_d = S_SHIFT_HI;
               phase_d = '0;
               sclk_d  = 1'b1;
            end
         end

         S_SHIFT_HI: begin
            sclk_d = 1'b1;
            if (phase_q == DIV_LAST) begin
               phase_d = '0;
               sclk_d  = 1'b0;
               if (bit_q == 4'd15) begin
                  state_d = S_LOAD;
                  bit_d   = '0;
                  load_d  = 1'b1;
               end else begin
                  state_d = S_SHIFT_LO;
                  bit_d   = bit_q + 4'd1;
                  shreg_d = {shreg_q[14:0], 1'b0};
                  din_d   = shreg_q[14];
               end
            end
         end

         S_LOAD: begin
            load_d = 1'b1;
            sclk_d = 1'b0;
            if (phase_q == LOAD_LAST) begin
               state_d = S_IDLE;
               phase_d = '0;
               load_d  = 1'b0;
               done_d  = 1'b1;
               ready_d = 1'b1;
               din_d   = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
            phase_d = '0;
         end
      endcase
   end

   assign o_ready        = ready_q;
   assign o_done         = done_q;
   assign o_max7219_clk  = sclk_q;
   assign o_max7219_din  = din_q;
   assign o_max7219_load = load_q;

endmodule

// File: tb/tb_max7219_ctrl.sv
// Directed bench for max7219_ctrl: three instances cover fast, nominal and slowest
// serial clock settings; a small MAX7219 receiver model sits on the nominal one.
module tb_max7219_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          sel = 0;
   logic        m_valid = 1'b0;
   logic [15:0] m_data = 16'h0000;

   always #5 clk = ~clk;

   logic a_valid, a_ready, a_done, a_sclk, a_din, a_load;
   logic b_valid, b_ready, b_done, b_sclk, b_din, b_load;
   logic c_valid, c_ready, c_done, c_sclk, c_din, c_load;
   logic m_ready, m_done, m_sclk, m_din, m_load;

   assign a_valid = m_valid && (sel == 0);
   assign b_valid = m_valid && (sel == 1);
   assign c_valid = m_valid && (sel == 2);
   assign m_ready = (sel == 0) ? a_ready : (sel == 1) ? b_ready : c_ready;
   assign m_done  = (sel == 0) ? a_done  : (sel == 1) ? b_done  : c_done;
   assign m_sclk  = (sel == 0) ? a_sclk  : (sel == 1) ? b_sclk  : c_sclk;
   assign m_din   = (sel == 0) ? a_din   : (sel == 1) ? b_din   : c_din;
   assign m_load  = (sel == 0) ? a_load  : (sel == 1) ? b_load  : c_load;

   max7219_ctrl #(.G_CLK_DIV(2), .G_LOAD_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .i_valid(a_valid), .i_data(m_data), .o_ready(a_ready),
      .o_done(a_done), .o_max7219_clk(a_sclk), .o_max7219_din(a_din), .o_max7219_load(a_load));
   max7219_ctrl #(.G_CLK_DIV(1), .G_LOAD_CYCLES(2)) dut_b (
      .clk(clk), .rst(rst), .i_valid(b_valid), .i_data(m_data), .o_ready(b_ready),
      .o_done(b_done), .o_max7219_clk(b_sclk), .o_max7219_din(b_din), .o_max7219_load(b_load));
   max7219_ctrl #(.G_CLK_DIV(255), .G_LOAD_CYCLES(2)) dut_c (
      .clk(clk), .rst(rst), .i_valid(c_valid), .i_data(m_data), .o_ready(c_ready),
      .o_done(c_done), .o_max7219_clk(c_sclk), .o_max7219_din(c_din), .o_max7219_load(c_load));

   // Receiver model: shifts on rising serial clock, latches on rising LOAD.
   logic [15:0] emu_sh = 16'h0000;
   logic [15:0] emu_frame = 16'h0000;
   logic [7:0]  emu_int = 8'h00;
   int          emu_loads = 0;
   always @(posedge a_sclk) emu_sh <= {emu_sh[14:0], a_din};
   always @(posedge a_load) begin
      emu_frame <= emu_sh;
      emu_loads <= emu_loads + 1;
      if (emu_sh[11:8] == 4'hA) emu_int <= emu_sh[7:0];
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] r_bits;
   int r_nrise, r_load_start, r_load_len, r_done1, r_done2, r_ndone;
   bit r_rise_ok, r_half_ok, r_hi_stable, r_ready_ok, r_load_ok, r_idle_ok, r_abort_zero;

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Handshakes d1 at the current negedge (cycle 0) and records what the pins do.
   task automatic capture(input logic [15:0] d1, input logic [15:0] d2, input bit hold,
                          input int div, input int budget, input int inj_cyc,
                          input logic [15:0] inj_data, input int abort_rise);
      int   fstart = 0;
      int   last_tr = 1;
      int   nr_f = 0;
      logic prev = 1'b0;
      logic hi_din = 1'b0;
      bit   aborted = 1'b0;
      r_bits = '0; r_nrise = 0; r_load_start = -1; r_load_len = 0;
      r_done1 = -1; r_done2 = -1; r_ndone = 0;
      r_rise_ok = 1; r_half_ok = 1; r_hi_stable = 1; r_ready_ok = 1;
      r_load_ok = 1; r_idle_ok = 1; r_abort_zero = 0;
      m_valid = 1'b1;
      m_data  = d1;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (c == 1 && !hold) m_valid = 1'b0;
         if (inj_cyc > 0 && c == inj_cyc) begin
            m_valid = 1'b1; m_data = inj_data;
         end else if (inj_cyc > 0 && c == inj_cyc + 1) begin
            m_valid = 1'b0; m_data = d1;
         end
         if (!aborted) begin
            if (m_sclk !== prev) begin
               if (c - last_tr != div) r_half_ok = 0;
               last_tr = c;
            end
            if (m_sclk === 1'b1 && prev === 1'b0) begin
               r_bits = {r_bits[30:0], m_din};
               if (c != fstart + 1 + div + 2 * nr_f * div) r_rise_ok = 0;
               nr_f++; r_nrise++;
               hi_din = m_din;
            end
            if (m_sclk === 1'b1 && m_din !== hi_din) r_hi_stable = 0;
            if (m_load === 1'b1) begin
               if (r_load_start < 0) r_load_start = c;
               r_load_len++;
               if (m_sclk !== 1'b0) r_load_ok = 0;
            end
            if (m_done === 1'b1) begin
               r_ndone++;
               if (m_ready !== 1'b1) r_ready_ok = 0;
               if (m_din !== 1'b0 || m_sclk !== 1'b0 || m_load !== 1'b0) r_idle_ok = 0;
               if (r_ndone == 1) r_done1 = c; else r_done2 = c;
               if (hold && r_ndone == 1) begin
                  m_data = d2; fstart = c; last_tr = c + 1; nr_f = 0;
               end else begin
                  m_valid = 1'b0;
                  break;
               end
            end else if (m_ready !== 1'b0) r_ready_ok = 0;
            if (abort_rise > 0 && r_nrise == abort_rise) begin
               rst = 1'b1;
               #1;
               r_abort_zero = ({m_ready, m_done, m_sclk, m_din, m_load} === 5'b0);
               aborted = 1'b1;
            end
         end else begin
            rst = 1'b0;
            if (m_load === 1'b1) r_load_len++;
            if (m_done === 1'b1) r_ndone++;
         end
         prev = m_sclk;
      end
   endtask

   task automatic test_reset();
      sel = 0;
      idle(3);
      n_cmp++; if ({a_ready, a_done, a_sclk, a_din, a_load} !== 5'b0) begin n_bad++;
         $display("FAIL reset_outs_a: got %b expected 00000", {a_ready, a_done, a_sclk, a_din, a_load}); end
      n_cmp++; if ({b_ready, b_load, c_ready, c_load, b_sclk, c_sclk} !== 6'b0) begin n_bad++;
         $display("FAIL reset_outs_bc: got %b expected 000000", {b_ready, b_load, c_ready, c_load, b_sclk, c_sclk}); end
      rst = 1'b0;
      #1;
      n_cmp++; if (m_ready !== 1'b0) begin n_bad++;
         $display("FAIL ready_before_edge: got %b expected 0", m_ready); end
      @(negedge clk);
      n_cmp++; if (m_ready !== 1'b1) begin n_bad++;
         $display("FAIL ready_after_edge: got %b expected 1", m_ready); end
   endtask

   task automatic test_frame_0a05();
      sel = 0;
      idle(2);
      capture(16'h0A05, 16'h0, 1'b0, 2, 80, 0, 16'h0, 0);
      n_cmp++; if (r_bits[15:0] !== 16'h0A05) begin n_bad++;
         $display("FAIL f0a05_bits: got %h expected 0a05", r_bits[15:0]); end
      n_cmp++; if (r_nrise != 16) begin n_bad++;
         $display("FAIL f0a05_nrise: got %0d expected 16", r_nrise); end
      n_cmp++; if ({r_rise_ok, r_half_ok, r_hi_stable} !== 3'b111) begin n_bad++;
         $display("FAIL f0a05_timing(rise,half,stable): got %b expected 111", {r_rise_ok, r_half_ok, r_hi_stable}); end
      n_cmp++; if (r_load_start != 65 || r_load_len != 2) begin n_bad++;
         $display("FAIL f0a05_load: got start %0d len %0d expected start 65 len 2", r_load_start, r_load_len); end
      n_cmp++; if (r_done1 != 67 || r_ndone != 1) begin n_bad++;
         $display("FAIL f0a05_done: got cycle %0d count %0d expected cycle 67 count 1", r_done1, r_ndone); end
      n_cmp++; if ({r_ready_ok, r_load_ok, r_idle_ok} !== 3'b111) begin n_bad++;
         $display("FAIL f0a05_ctrl(ready,load,idle): got %b expected 111", {r_ready_ok, r_load_ok, r_idle_ok}); end
      n_cmp++; if (emu_int !== 8'h05) begin n_bad++;
         $display("FAIL f0a05_intensity: got %h expected 05", emu_int); end
   endtask

   task automatic test_back_to_back();
      sel = 1;
      idle(2);
      n_cmp++; if (m_ready !== 1'b1) begin n_bad++;
         $display("FAIL b2b_ready_start: got %b expected 1", m_ready); end
      capture(16'hFFFF, 16'h0000, 1'b1, 1, 100, 0, 16'h0, 0);
      n_cmp++; if (r_bits !== 32'hFFFF0000) begin n_bad++;
         $display("FAIL b2b_bits: got %h expected ffff0000", r_bits); end
      n_cmp++; if (r_nrise != 32 || !r_rise_ok || !r_half_ok) begin n_bad++;
         $display("FAIL b2b_edges: got %0d rises ok=%b%b expected 32 ok=11", r_nrise, r_rise_ok, r_half_ok); end
      n_cmp++; if (r_done1 != 35 || r_done2 - r_done1 != 35) begin n_bad++;
         $display("FAIL b2b_done: got %0d,%0d expected 35,70", r_done1, r_done2); end
      n_cmp++; if (r_load_len != 4 || !r_ready_ok || !r_idle_ok) begin n_bad++;
         $display("FAIL b2b_ctrl: got load %0d ready_ok %b idle_ok %b expected 4 1 1", r_load_len, r_ready_ok, r_idle_ok); end
   endtask

   task automatic test_ignore_busy();
      int loads0;
      sel = 0;
      idle(2);
      loads0 = emu_loads;
      capture(16'h0F00, 16'h0, 1'b0, 2, 80, 10, 16'h0C01, 0);
      n_cmp++; if (r_bits[15:0] !== 16'h0F00 || r_nrise != 16) begin n_bad++;
         $display("FAIL busy_bits: got %h (%0d rises) expected 0f00 (16)", r_bits[15:0], r_nrise); end
      n_cmp++; if (r_done1 != 67) begin n_bad++;
         $display("FAIL busy_done: got %0d expected 67", r_done1); end
      idle(4);
      n_cmp++; if (emu_frame !== 16'h0F00 || emu_loads != loads0 + 1) begin n_bad++;
         $display("FAIL busy_emu: got %h loads +%0d expected 0f00 +1", emu_frame, emu_loads - loads0); end
      n_cmp++; if (m_ready !== 1'b1 || m_sclk !== 1'b0) begin n_bad++;
         $display("FAIL busy_no_second: got ready %b sclk %b expected 1 0", m_ready, m_sclk); end
   endtask

   task automatic test_reset_abort();
      int loads0;
      sel = 0;
      idle(2);
      loads0 = emu_loads;
      capture(16'h0155, 16'h0, 1'b0, 2, 80, 0, 16'h0, 7);
      n_cmp++; if (r_abort_zero !== 1'b1 || r_nrise != 7) begin n_bad++;
         $display("FAIL abort_outs: got zero=%b rises=%0d expected 1 7", r_abort_zero, r_nrise); end
      n_cmp++; if (r_load_len != 0 || r_ndone != 0 || emu_loads != loads0) begin n_bad++;
         $display("FAIL abort_quiet: got load %0d done %0d emu +%0d expected 0 0 0", r_load_len, r_ndone, emu_loads - loads0); end
      n_cmp++; if (m_ready !== 1'b1) begin n_bad++;
         $display("FAIL abort_ready: got %b expected 1", m_ready); end
      capture(16'h0B07, 16'h0, 1'b0, 2, 80, 0, 16'h0, 0);
      n_cmp++; if (r_bits[15:0] !== 16'h0B07 || r_done1 != 67 || r_load_start != 65) begin n_bad++;
         $display("FAIL after_abort: got %h done %0d load %0d expected 0b07 67 65", r_bits[15:0], r_done1, r_load_start); end
      idle(2);
      n_cmp++; if (emu_frame !== 16'h0B07) begin n_bad++;
         $display("FAIL after_abort_emu: got %h expected 0b07", emu_frame); end
   endtask

   task automatic test_slow();
      sel = 2;
      idle(2);
      capture(16'h0801, 16'h0, 1'b0, 255, 8300, 0, 16'h0, 0);
      n_cmp++; if (r_bits[15:0] !== 16'h0801 || r_nrise != 16) begin n_bad++;
         $display("FAIL slow_bits: got %h (%0d rises) expected 0801 (16)", r_bits[15:0], r_nrise); end
      n_cmp++; if ({r_rise_ok, r_half_ok, r_hi_stable} !== 3'b111) begin n_bad++;
         $display("FAIL slow_timing(rise,half,stable): got %b expected 111", {r_rise_ok, r_half_ok, r_hi_stable}); end
      n_cmp++; if (r_load_start != 8161 || r_done1 != 8163) begin n_bad++;
         $display("FAIL slow_duration: got load %0d done %0d expected 8161 8163", r_load_start, r_done1); end
   endtask

   initial begin
      test_reset();
      test_frame_0a05();
      test_back_to_back();
      test_ignore_busy();
      test_reset_abort();
      test_slow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
